// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and datapath widths.
// Used by the receiver now and by the transmitter after its cleanup.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BPS_W     = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer with a falling-edge detector.
// Edges are only reported once the pipe holds real line samples after reset.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A line already low at reset release must not look like a start edge.
    assign rx_s = r_sync[SYNC_STAGES-1];
    assign fall = r_fill[SYNC_STAGES] & r_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-bit qualification, mid-bit sampling,
// one-cycle rx_done / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [BPS_W-1:0]     bps,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    state_t               r_state;
    state_t               w_next;
    logic [BPS_W-1:0]     r_cnt;
    logic [BPS_W-1:0]     r_bps_l;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_last;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_in(rx_in),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

    assign w_mid  = (r_cnt == (r_bps_l >> 1));
    assign w_end  = (r_cnt == r_bps_l);
    assign w_last = (r_bit_idx == 3'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_mid) w_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_end && w_last) w_next = STOP;
            STOP:    if (w_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        data_out  = r_data;
        rx_done   = r_done;
        frame_err = r_ferr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bps_l   <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) r_bps_l <= bps;
                end
                START: begin
                    if (w_mid) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                DATA: begin
                    if (w_end) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (!w_last) r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                STOP: begin
                    if (w_end) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data <= r_shreg;
                            r_done <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue expected strobes,
// a monitor pops and checks kind, data and arrival cycle.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_in = 1'b1;
    logic [16:0] bps = 17'd9;
    logic [7:0]  data_out;
    logic        rx_done;
    logic        frame_err;
    logic        busy;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .bps      (bps),
        .data_out (data_out),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    int         n_pass = 0;
    int         n_tot  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    task automatic hold_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Caller sits on a negedge; the line falls before the next posedge (E0).
    task automatic send(input logic [7:0] b, input bit ok, input int bp);
        exp_t e;
        e.err  = !ok;
        e.data = ok ? b : last_good;
        e.due  = cyc + 1 + (bp >> 1) + 3 + 9 * (bp + 1);
        q.push_back(e);
        if (ok) last_good = b;
        hold_bit(1'b0, bp + 1);
        for (int i = 0; i < 8; i++) hold_bit(b[i], bp + 1);
        hold_bit(ok, bp + 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rx_done || frame_err) begin
                if (rx_done && frame_err) begin
                    n_tot++;
                    $display("FAIL both_pulses: rx_done=1 frame_err=1");
                end
                if (q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b cyc=%0d",
                             rx_done, frame_err, cyc);
                end else begin
                    m_e = q.pop_front();
                    check("pulse_kind", 32'(frame_err), 32'(m_e.err));
                    check("pulse_not_done", 32'(rx_done), 32'(!m_e.err));
                    check("data_out", 32'(data_out), 32'(m_e.data));
                    check("busy_drop", 32'(busy), 32'd0);
                    n_tot++;
                    if (cyc >= m_e.due - 1 && cyc <= m_e.due + 1) n_pass++;
                    else $display("FAIL latency: got cyc %0d want %0d", cyc, m_e.due);
                end
            end
        end
    end

    initial begin
        bit saw;
        logic [7:0] lb [4];
        lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;

        repeat (4) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        send(8'hA5, 1'b1, 9);
        repeat (5) @(negedge clk);

        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_data", 32'(data_out), 32'hA5);

        send(8'h3C, 1'b0, 9);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_data_held", 32'(data_out), 32'hA5);

        send(8'h00, 1'b1, 9);
        send(8'hFF, 1'b1, 9);
        repeat (10) @(negedge clk);

        hold_bit(1'b0, 10);
        hold_bit(1'b1, 10);
        hold_bit(1'b0, 10);
        hold_bit(1'b0, 10);
        hold_bit(1'b0, 10);
        hold_bit(1'b0, 5);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data", 32'(data_out), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(rx_done), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        last_good = 8'h00;
        repeat (30) @(negedge clk);
        check("low_at_release", 32'(busy), 32'd0);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h5A, 1'b1, 9);
        repeat (10) @(negedge clk);

        bps = 17'd433;
        for (int i = 0; i < 4; i++) send(lb[i], 1'b1, 433);
        fork
            send(8'hC3, 1'b1, 433);
            begin
                repeat (1500) @(negedge clk);
                bps = 17'd9;
            end
        join
        bps = 17'd433;

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_tot++;
            $display("FAIL drain: %0d pulses missing", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
